// File: rtl/sipo_rx.sv
// MSB-first serial receiver: rebuilds WIDTH-bit words into a DEPTH-entry FIFO, and counts and flags delivered words.
// A word is visible one cycle after its LSB; a full FIFO drops the incoming word unless the head pops on that same edge.

module sipo_rx_fifo #(
  parameter int W     = 75,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         vld,
  output logic         full,
  output logic         drop,
  output logic         pop_ok
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rptr;
  logic [AW-1:0] wptr;
  logic [AW:0]   cnt;
  logic          push_ok;

  assign vld     = (cnt != '0);
  assign full    = (cnt == FULL_CNT);
  assign pop_ok  = pop && vld;
  // A full FIFO still takes a word when the head leaves on the same edge.
  assign push_ok = push && (!full || pop_ok);
  assign drop    = push && !push_ok;
  assign dout    = mem[rptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push_ok) begin
      mem[wptr] <= push_dat;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rptr <= '0;
      wptr <= '0;
      cnt  <= '0;
    end else begin
      if (pop_ok)  rptr <= rptr + 1'b1;
      if (push_ok) wptr <= wptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

module sipo_rx #(
  parameter int WIDTH = 75,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sin,
  input  logic             last,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             full,
  output logic             overflow,
  output logic             frame_err,
  output logic [2:0]       row
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  logic [WIDTH-2:0] sr;
  logic [CW-1:0]    cnt;
  logic             done;
  logic             early;
  logic             drop;
  logic             pop_ok;
  logic [WIDTH-1:0] word;

  assign done  = en && (cnt == LAST_IDX);
  assign early = en && last && (cnt != LAST_IDX);
  assign word  = {sr, sin};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr  <= '0;
      cnt <= '0;
    end else if (en) begin
      // Completion or an early last both resync to the first bit of the next word.
      if (done || early) begin
        cnt <= '0;
      end else begin
        sr  <= {sr[WIDTH-3:0], sin};
        cnt <= cnt + 1'b1;
      end
    end
  end

  sipo_rx_fifo #(
    .W     (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (done),
    .push_dat (word),
    .pop      (dout_ready),
    .dout     (dout),
    .vld      (dout_valid),
    .full     (full),
    .drop     (drop),
    .pop_ok   (pop_ok)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow  <= 1'b0;
      frame_err <= 1'b0;
      row       <= 3'd0;
    end else begin
      if (drop) overflow <= 1'b1;
      if (early || (done && !last)) frame_err <= 1'b1;
      if (pop_ok) row <= row + 3'd1;
    end
  end
endmodule

// File: tb/tb_sipo_rx.sv
// Directed bench for sipo_rx with a scoreboard queue of expected words.
module tb_sipo_rx;
  localparam int W = 75;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0;
  logic         sin = 1'b0;
  logic         last = 1'b0;
  logic [W-1:0] dout;
  logic         dout_valid;
  logic         dout_ready = 1'b0;
  logic         full;
  logic         overflow;
  logic         frame_err;
  logic [2:0]   row;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] head;
  int           n_chk = 0;
  int           n_pass = 0;
  logic [2:0]   exp_row = 3'd0;

  logic [W-1:0] wset [8];

  sipo_rx #(.WIDTH(W), .DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .sin        (sin),
    .last       (last),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .full       (full),
    .overflow   (overflow),
    .frame_err  (frame_err),
    .row        (row)
  );

  always #5 clk = ~clk;

  task automatic chkb(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chkw(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic send_bit(input logic b, input logic l, input logic rdy);
    en = 1'b1; sin = b; last = l; dout_ready = rdy;
    @(posedge clk); #1;
    en = 1'b0; sin = 1'b0; last = 1'b0; dout_ready = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic mark_last,
                           input logic gaps, input logic rdy_last);
    for (int i = W - 1; i >= 0; i--) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      end
      send_bit(w[i], mark_last && (i == 0), rdy_last && (i == 0));
    end
  endtask

  task automatic take_word(input string tag);
    chkb({tag, "_valid"}, 8'(dout_valid), 8'd1);
    if (exp_q.size() == 0) begin
      n_chk++;
      $error("FAIL %s_sb observed=empty-queue expected=entry", tag);
    end else begin
      head = exp_q.pop_front();
      chkw({tag, "_dout"}, dout, head);
    end
    dout_ready = 1'b1;
    @(posedge clk); #1;
    dout_ready = 1'b0;
    exp_row = exp_row + 3'd1;
    chkb({tag, "_row"}, 8'(row), 8'(exp_row));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    rst = 1'b1;
    exp_q.delete();
    exp_row = 3'd0;
    @(posedge clk); #1;
  endtask

  initial begin
    wset[0] = 75'h4204016000000000001;
    wset[1] = 75'h0004023000000000000;
    wset[2] = 75'h00040234CCCC0000000;
    wset[3] = 75'h0003FD06C4C5974E65C;
    wset[4] = 75'h00040B41E83DD97F62B;
    wset[5] = 75'h000407F48BC6A7EF9DB;
    wset[6] = 75'h000C0100FF20BD91970;
    wset[7] = 75'h2AAAA5555F0F0C3C3A5;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chkw("rst_dout", dout, '0);
    chkb("rst_valid", 8'(dout_valid), 8'd0);
    chkb("rst_full", 8'(full), 8'd0);
    chkb("rst_ovf", 8'(overflow), 8'd0);
    chkb("rst_ferr", 8'(frame_err), 8'd0);
    chkb("rst_row", 8'(row), 8'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Single word: visible exactly one cycle after its LSB
    for (int i = W - 1; i >= 1; i--) send_bit(wset[0][i], 1'b0, 1'b0);
    chkb("single_pre_valid", 8'(dout_valid), 8'd0);
    send_bit(wset[0][0], 1'b1, 1'b0);
    exp_q.push_back(wset[0]);
    take_word("single");
    chkb("single_empty", 8'(dout_valid), 8'd0);
    chkb("single_ferr", 8'(frame_err), 8'd0);
    chkb("single_ovf", 8'(overflow), 8'd0);

    // Full FIFO with a pop on the completing edge
    for (int k = 1; k <= 4; k++) begin
      send_word(wset[k], 1'b1, 1'b0, 1'b0);
      exp_q.push_back(wset[k]);
    end
    chkb("pp_full_before", 8'(full), 8'd1);
    chkw("pp_head_before", dout, exp_q[0]);
    send_word(wset[5], 1'b1, 1'b0, 1'b1);
    void'(exp_q.pop_front());
    exp_row = exp_row + 3'd1;
    exp_q.push_back(wset[5]);
    chkb("pp_full_after", 8'(full), 8'd1);
    chkb("pp_ovf", 8'(overflow), 8'd0);
    chkb("pp_row", 8'(row), 8'(exp_row));
    for (int k = 0; k < 4; k++) take_word("pp_drain");
    chkb("pp_empty", 8'(dout_valid), 8'd0);

    // Overflow: fifth word dropped
    for (int k = 1; k <= 5; k++) begin
      send_word(wset[k], 1'b1, 1'b0, 1'b0);
      if (k <= 4) exp_q.push_back(wset[k]);
      if (k == 4) begin
        chkb("ovf_full4", 8'(full), 8'd1);
        chkb("ovf_flag4", 8'(overflow), 8'd0);
      end
    end
    chkb("ovf_flag5", 8'(overflow), 8'd1);
    chkb("ovf_full5", 8'(full), 8'd1);
    for (int k = 0; k < 4; k++) take_word("ovf_drain");
    chkb("ovf_empty", 8'(dout_valid), 8'd0);
    chkb("ovf_sticky", 8'(overflow), 8'd1);

    // Reset mid-word with a stored word pending
    send_word(wset[7], 1'b1, 1'b0, 1'b0);
    for (int i = W - 1; i > W - 41; i--) send_bit(wset[6][i], 1'b0, 1'b0);
    rst = 1'b0;
    #2;
    chkw("mid_rst_dout", dout, '0);
    chkb("mid_rst_valid", 8'(dout_valid), 8'd0);
    chkb("mid_rst_full", 8'(full), 8'd0);
    chkb("mid_rst_ovf", 8'(overflow), 8'd0);
    chkb("mid_rst_row", 8'(row), 8'd0);
    rst = 1'b1;
    exp_q.delete();
    exp_row = 3'd0;
    @(posedge clk); #1;
    send_word(wset[2], 1'b1, 1'b0, 1'b0);
    exp_q.push_back(wset[2]);
    take_word("clean");
    chkb("clean_empty", 8'(dout_valid), 8'd0);
    chkb("clean_ferr", 8'(frame_err), 8'd0);

    // Early last after 10 bits
    for (int i = W - 1; i > W - 11; i--) send_bit(wset[3][i], (i == W - 10), 1'b0);
    chkb("early_ferr", 8'(frame_err), 8'd1);
    @(posedge clk); #1;
    chkb("early_nopush", 8'(dout_valid), 8'd0);
    send_word(wset[6], 1'b1, 1'b0, 1'b0);
    exp_q.push_back(wset[6]);
    take_word("early_follow");

    // Missing last with en gaps
    do_reset();
    chkb("gap_ferr_pre", 8'(frame_err), 8'd0);
    send_word(wset[4], 1'b0, 1'b1, 1'b0);
    exp_q.push_back(wset[4]);
    chkb("gap_ferr", 8'(frame_err), 8'd1);
    take_word("gap");
    chkb("gap_empty", 8'(dout_valid), 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
